// File: rtl/instr_encoder.sv
// Packs decoded MIPS-subset instruction fields into 32-bit words and streams them
// into consecutive instruction-memory addresses, flagging the first illegal bundle.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic [31:0] word;
  logic        op_illegal;
  logic        range_bad;
  logic        accept;

  // Field packing and range check for the bundle currently on the inputs
  always_comb begin
    word       = '0;
    op_illegal = 1'b0;
    range_bad  = 1'b0;
    case (in_op)
      5'd0: word = {in_op, in_rs, in_rt, in_rd, 12'd0};
      5'd2, 5'd3: begin
        word      = {in_op, in_imm[26:0]};
        range_bad = |in_imm[31:27];
      end
      5'd1, 5'd10, 5'd11: begin
        word      = {in_op, in_rs, in_rt, 1'b0, in_imm[15:0]};
        range_bad = |in_imm[31:16];
      end
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        word      = {in_op, in_rs, in_rt, 1'b0, in_imm[15:0]};
        range_bad = !((&in_imm[31:15]) || !(|in_imm[31:15]));
      end
      default: op_illegal = 1'b1;
    endcase
  end

  assign full     = (count_q == FULL_COUNT);
  assign in_ready = (state_q == IDLE) && !full;
  assign accept   = in_valid && in_ready;

  // Next-state logic; clear wins over everything except reset
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_illegal || range_bad) begin
            if (!err_q) begin
              err_d  = 1'b1;
              code_d = op_illegal ? 2'b01 : 2'b10;
            end
            if (in_last) state_d = DONE;
          end else begin
            state_d = WRITE;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = word;
            last_d  = in_last;
          end
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        state_d = last_q ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2): directed vector table, corner
// sequences for full/reset, and random bundles against an arithmetic reference model.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_last;
  logic              in_ready;
  logic [4:0]        in_op, in_rs, in_rt, in_rd;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, done, err;
  logic [1:0]        err_code;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              addr;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;
  wr_t actQ[$];

  // Every observed memory write is collected here
  always @(negedge clk) if (imem_we) actQ.push_back('{1'b1, imem_addr, imem_wdata});

  typedef struct {
    logic        doClear;
    logic [4:0]  op, rs, rt, rd;
    logic [31:0] imm;
    logic        last;
    logic        expWe;
    logic [31:0] expWord;
    logic [1:0]  expCode;
  } vec_t;
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  int   mCount;
  logic mErr, mDone;
  logic [1:0] mCode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: legality and packing from plain integer arithmetic
  task automatic modelStep(input logic [4:0] op, rs, rt, rd, input logic [31:0] imm,
                           input logic last, output logic we, output logic [31:0] w,
                           output logic [1:0] a);
    longint s = longint'($signed(imm));
    longint u = longint'(imm);
    longint acc;
    int code = 0;
    if (op > 11) code = 1;
    else if (op >= 4 && op <= 9) begin if (s < -32768 || s > 32767) code = 2; end
    else if (op == 1 || op == 10 || op == 11) begin if (u > 65535) code = 2; end
    else if (op == 2 || op == 3) begin if (u >= 134217728) code = 2; end
    if (op == 0)                 acc = op * 134217728 + rs * 4194304 + rt * 131072 + rd * 4096;
    else if (op == 2 || op == 3) acc = op * 134217728 + u;
    else                         acc = op * 134217728 + rs * 4194304 + rt * 131072 + (u % 65536);
    w  = acc[31:0];
    a  = 2'(mCount % DEPTH);
    we = (code == 0);
    if (code != 0 && !mErr) begin mErr = 1'b1; mCode = 2'(code); end
    if (we) mCount++;
    if (last) mDone = 1'b1;
  endtask

  task automatic modelClear();
    mCount = 0; mErr = 1'b0; mCode = 2'b00; mDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] op, rs, rt, rd, input logic [31:0] imm,
                               input logic last);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 10) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      check("readyTimeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic expWe, input logic [ADDR_W-1:0] expAddr,
                             input logic [31:0] expWord, input logic [1:0] expCode);
    logic expFull;
    expFull = (mCount == DEPTH);
    check({tag, ".writes"}, actQ.size(), expWe ? 1 : 0);
    if (expWe && actQ.size() == 1) begin
      check({tag, ".addr"}, 32'(actQ[0].a), 32'(expAddr));
      check({tag, ".wdata"}, actQ[0].d, expWord);
    end
    actQ.delete();
    check({tag, ".count"}, 32'(count), mCount);
    check({tag, ".full"}, 32'(full), 32'(expFull));
    check({tag, ".done"}, 32'(done), 32'(mDone));
    check({tag, ".ready"}, 32'(in_ready), 32'(!mDone && !expFull));
    check({tag, ".err"}, 32'(err), 32'(expCode != 2'b00));
    check({tag, ".code"}, 32'(err_code), 32'(expCode));
  endtask

  task automatic clearSession();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    modelClear();
    @(negedge clk);
    actQ.delete();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".we"}, 32'(imem_we), 0);
    check({tag, ".addr"}, 32'(imem_addr), 0);
    check({tag, ".wdata"}, imem_wdata, 0);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".ready"}, 32'(in_ready), 1);
    check({tag, ".flags"}, {28'd0, full, done, err_code[1] | err, err_code[0]}, 0);
  endtask

  initial begin
    logic        we;
    logic [31:0] w;
    logic [1:0]  a;
    logic [31:0] edges[10];
    edges = '{32'd0, 32'd32767, 32'd32768, 32'd65535, 32'd65536, 32'hFFFFFFFF,
              32'hFFFF8000, 32'hFFFF7FFF, 32'h07FFFFFF, 32'h08000000};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    modelClear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkResetValues("reset");
    actQ.delete();

    //           clr op  rs  rt  rd  imm            last we  word           code
    vecs.push_back('{0, 0,  1,  2,  3, 32'd0,         0, 1, 32'h00443000, 2'b00});
    vecs.push_back('{0, 7,  4,  5,  0, 32'hFFFFFFFF,  0, 1, 32'h390AFFFF, 2'b00});
    vecs.push_back('{0, 10, 1,  1,  0, 32'h00010000,  0, 0, 32'h0,        2'b10});
    vecs.push_back('{0, 12, 0,  0,  0, 32'd0,         0, 0, 32'h0,        2'b10});
    vecs.push_back('{0, 6,  1,  2,  0, 32'h10,        0, 1, 32'h30440010, 2'b10});
    vecs.push_back('{0, 3,  0,  0,  0, 32'h123,       1, 1, 32'h18000123, 2'b10});
    vecs.push_back('{1, 7,  0,  0,  0, 32'd32767,     0, 1, 32'h38007FFF, 2'b00});
    vecs.push_back('{0, 8,  0,  0,  0, 32'hFFFF8000,  0, 1, 32'h40008000, 2'b00});
    vecs.push_back('{0, 9,  0,  0,  0, 32'd32768,     0, 0, 32'h0,        2'b10});
    vecs.push_back('{1, 11, 0,  0,  0, 32'd65535,     0, 1, 32'h5800FFFF, 2'b00});
    vecs.push_back('{0, 1,  0,  0,  0, 32'hFFFFFFFF,  0, 0, 32'h0,        2'b10});
    vecs.push_back('{1, 2,  0,  0,  0, 32'h07FFFFFF,  0, 1, 32'h17FFFFFF, 2'b00});
    vecs.push_back('{0, 2,  0,  0,  0, 32'h08000000,  0, 0, 32'h0,        2'b10});
    vecs.push_back('{1, 31, 0,  0,  0, 32'd0,         0, 0, 32'h0,        2'b01});
    vecs.push_back('{0, 10, 0,  0,  0, 32'h00020000,  0, 0, 32'h0,        2'b01});
    vecs.push_back('{0, 5,  31, 31, 0, 32'h1234,      0, 1, 32'h2FFE1234, 2'b01});
    vecs.push_back('{0, 4,  2,  3,  0, 32'hFFFF8000,  0, 1, 32'h20868000, 2'b01});
    vecs.push_back('{0, 13, 0,  0,  0, 32'd0,         1, 0, 32'h0,        2'b01});

    foreach (vecs[i]) begin
      if (vecs[i].doClear) begin
        clearSession();
        checkOutput($sformatf("vec%0d.clear", i), 1'b0, '0, '0, 2'b00);
      end
      a = 2'(mCount % DEPTH);
      if (vecs[i].expWe) mCount++;
      if (vecs[i].last) mDone = 1'b1;
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].last);
      checkOutput($sformatf("vec%0d", i), vecs[i].expWe, a, vecs[i].expWord, vecs[i].expCode);
    end
    clearSession();

    // Fill memory, then hold in_valid high: nothing more may be written
    for (int i = 0; i < DEPTH; i++) begin
      modelStep(5'd7, 5'(i), 5'(i + 1), 5'd0, 32'(i * 3), 1'b0, we, w, a);
      applyStimulus(5'd7, 5'(i), 5'(i + 1), 5'd0, 32'(i * 3), 1'b0);
      checkOutput($sformatf("fill%0d", i), we, a, w, mCode);
    end
    @(negedge clk);
    in_op = 5'd0; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("overfill", 1'b0, '0, '0, 2'b00);
    clearSession();

    // Reset landing in the WRITE cycle of the second word
    modelStep(5'd12, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, we, w, a);
    applyStimulus(5'd12, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    modelStep(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, we, w, a);
    applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    checkOutput("preReset", we, a, w, mCode);
    @(negedge clk);
    in_op = 5'd7; in_rs = 5'd2; in_rt = 5'd2; in_imm = 32'd9; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("midWrite.we", 32'(imem_we), 1);
    check("midWrite.addr", 32'(imem_addr), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkResetValues("resetInWrite");
    modelClear();
    @(negedge clk);
    actQ.delete();
    modelStep(5'd11, 5'd3, 5'd4, 5'd0, 32'h00ABCD, 1'b0, we, w, a);
    applyStimulus(5'd11, 5'd3, 5'd4, 5'd0, 32'h00ABCD, 1'b0);
    checkOutput("postReset", we, a, w, mCode);

    // Random bundles against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op, rs, rt, rd;
      logic [31:0] imm;
      logic        last;
      if (mDone || mCount == DEPTH) clearSession();
      op = 5'($urandom_range(0, 13));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 65535));
        2:       imm = edges[$urandom_range(0, 9)];
        default: imm = $urandom & 32'h07FFFFFF;
      endcase
      last = ($urandom_range(0, 7) == 0);
      modelStep(op, rs, rt, rd, imm, last, we, w, a);
      applyStimulus(op, rs, rt, rd, imm, last);
      checkOutput($sformatf("rand%0d", i), we, a, w, mCode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
